// File: rtl/audio_pkg.sv
// audio_pkg: shared types and defaults for the PCM serializer slice.
`default_nettype none

package audio_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int CLK_DIV_DEF = 2;
  localparam int BIT_CNT_W   = $clog2(DATA_W_DEF);

  // Counter width for an arbitrary word size; never collapses to zero bits.
  function automatic int bitcnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_bclk_gen.sv
// audio_bclk_gen: clk divider producing bclk and its rise/fall ticks while run is high.
`default_nettype none

module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic             w_tick;

  assign w_tick = run && (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (!run) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  assign bclk      = r_bclk;
  assign rise_tick = w_tick & ~r_bclk;
  assign fall_tick = w_tick &  r_bclk;

endmodule

`default_nettype wire

// File: rtl/audio_pcm_serializer.sv
// audio_pcm_serializer: MSB-first PCM word serializer with generated bit clock.
// Optional macro AUDIO_LRCLK_EN adds an lrclk output toggling at each word start.
`default_nettype none

module audio_pcm_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] d_in,
  output logic              bclk,
  output logic              d_out,
  output logic              done,
`ifdef AUDIO_LRCLK_EN
  output logic              lrclk,
`endif
  output logic              act
);

  localparam int CNT_W = bitcnt_w(DATA_W);

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              w_rise_tick;
  logic              w_fall_tick;
  logic              w_last;
`ifdef AUDIO_LRCLK_EN
  logic              r_lrclk;
`endif

  audio_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (act),
    .bclk      (bclk),
    .rise_tick (w_rise_tick),
    .fall_tick (w_fall_tick)
  );

  assign w_last = (r_bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
`ifdef AUDIO_LRCLK_EN
      r_lrclk   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= SHIFT;
            r_shift   <= d_in;
            r_bit_cnt <= '0;
`ifdef AUDIO_LRCLK_EN
            r_lrclk   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (w_fall_tick) begin
            if (!w_last) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
            end else if (enable) begin
              // Reload on the boundary edge so the next word follows with no gap bit.
              r_shift   <= d_in;
              r_bit_cnt <= '0;
`ifdef AUDIO_LRCLK_EN
              r_lrclk   <= ~r_lrclk;
`endif
            end else begin
              r_state   <= IDLE;
              r_shift   <= '0;
              r_bit_cnt <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The shift register MSB is the serial line, so d_out is a register bit.
  assign d_out = r_shift[DATA_W-1];
  assign act   = (r_state == SHIFT);
  assign done  = (r_state == SHIFT) && w_fall_tick && w_last;
`ifdef AUDIO_LRCLK_EN
  assign lrclk = r_lrclk;
`endif

  a_tick_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(w_rise_tick && w_fall_tick));

endmodule

`default_nettype wire

// File: tb/tb_audio_pcm_serializer.sv
// tb_audio_pcm_serializer: directed self-checking bench for audio_pcm_serializer.
`default_nettype none

module tb_audio_pcm_serializer;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] d_in = '0;
  logic bclk0, dout0, done0, act0;
  logic bclk1, dout1, done1, act1;
`ifdef AUDIO_LRCLK_EN
  logic lr0, lr1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_bits[$];
  int   cap_done[$];
  int   cap_rise[$];
  logic cap_lr[$];
  int   act_cnt;
  logic act_last;

  always #5 clk = ~clk;

  audio_pcm_serializer #(.DATA_W(DATA_W), .CLK_DIV(2)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .d_in(d_in),
    .bclk(bclk0), .d_out(dout0), .done(done0),
`ifdef AUDIO_LRCLK_EN
    .lrclk(lr0),
`endif
    .act(act0)
  );

  audio_pcm_serializer #(.DATA_W(DATA_W), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .d_in(d_in),
    .bclk(bclk1), .d_out(dout1), .done(done1),
`ifdef AUDIO_LRCLK_EN
    .lrclk(lr1),
`endif
    .act(act1)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; d_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_start(input logic [DATA_W-1:0] din);
    @(negedge clk);
    enable = 1'b1; d_in = din;
  endtask

  // Sample i is taken on the negedge following the i-th posedge after the start edge.
  task automatic capture(input int ncyc, input int sel, input int en_off_at,
                         input int din_at, input logic [DATA_W-1:0] din_new);
    logic pb, b, d, dn, a;
    pb = 1'b0;
    cap_bits.delete(); cap_done.delete(); cap_rise.delete(); cap_lr.delete();
    act_cnt = 0; act_last = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sel == 0) begin b = bclk0; d = dout0; dn = done0; a = act0; end
      else          begin b = bclk1; d = dout1; dn = done1; a = act1; end
`ifdef AUDIO_LRCLK_EN
      cap_lr.push_back(sel == 0 ? lr0 : lr1);
`endif
      if (b && !pb) begin cap_bits.push_back(d); cap_rise.push_back(i); end
      pb = b;
      if (dn) cap_done.push_back(i);
      if (a) act_cnt++;
      act_last = a;
      if (i == en_off_at) enable = 1'b0;
      if (i == din_at) d_in = din_new;
    end
  endtask

  function automatic logic [31:0] pack_bits();
    logic [31:0] w;
    w = '0;
    foreach (cap_bits[k]) w = {w[30:0], cap_bits[k]};
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; d_in = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bclk0, dout0, done0, act0} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, {bclk0, dout0, done0, act0});
      end
    end
  endtask

  task automatic test_single_word();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; d_in = 16'h5A60;
    capture(66, 0, 3, -1, '0);
    n_checks++;
    if (cap_bits.size() != 16 || pack_bits() !== 32'h0000_5A60) begin
      n_fail++;
      $display("FAIL single_bits got=%h n=%0d exp=5a60 n=16", pack_bits(), cap_bits.size());
    end
    n_checks++;
    if (cap_done.size() != 1 || cap_done[0] != 63) begin
      n_fail++;
      $display("FAIL single_done n=%0d first=%0d exp n=1 at 63", cap_done.size(),
               cap_done.size() > 0 ? cap_done[0] : -1);
    end
    n_checks++;
    if (act_cnt != 64 || act_last !== 1'b0) begin
      n_fail++;
      $display("FAIL single_act cnt=%0d last=%b exp cnt=64 last=0", act_cnt, act_last);
    end
    n_checks++;
    if (cap_rise.size() < 2 || cap_rise[0] != 2 || cap_rise[1] - cap_rise[0] != 4) begin
      n_fail++;
      $display("FAIL single_bclk_timing first_rise=%0d exp first=2 period=4",
               cap_rise.size() > 0 ? cap_rise[0] : -1);
    end
    n_checks++;
    if ({bclk0, dout0} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle_lines got=%b exp=00", {bclk0, dout0});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start(16'h5A60);
    capture(131, 0, 70, 0, 16'hFFFF);
    n_checks++;
    if (cap_bits.size() != 32 || pack_bits() !== 32'h5A60_FFFF) begin
      n_fail++;
      $display("FAIL stream_bits got=%h n=%0d exp=5a60ffff n=32", pack_bits(), cap_bits.size());
    end
    n_checks++;
    if (cap_done.size() != 2 || cap_done[0] != 63 || cap_done[1] != 127) begin
      n_fail++;
      $display("FAIL stream_done n=%0d exp 63,127", cap_done.size());
    end
    n_checks++;
    if (act_cnt != 128 || act_last !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_act cnt=%0d last=%b exp cnt=128 last=0", act_cnt, act_last);
    end
  endtask

  task automatic test_mid_word_changes();
    do_reset();
    do_start(16'h5A60);
    capture(66, 0, 32, 20, 16'h0000);
    n_checks++;
    if (cap_bits.size() != 16 || pack_bits() !== 32'h0000_5A60) begin
      n_fail++;
      $display("FAIL midword_bits got=%h n=%0d exp=5a60", pack_bits(), cap_bits.size());
    end
    n_checks++;
    if (cap_done.size() != 1 || act_cnt != 64 || act_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midword_end done_n=%0d act_cnt=%0d last=%b exp 1/64/0",
               cap_done.size(), act_cnt, act_last);
    end
  endtask

  task automatic test_reset_mid_word();
    logic bad;
    do_reset();
    do_start(16'h5A60);
    repeat (28) @(negedge clk);
    n_checks++;
    if (act0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_active got=%b exp=1", act0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bclk0, dout0, done0, act0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_abort got=%b exp=0000", {bclk0, dout0, done0, act0});
    end
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done0 !== 1'b0 || act0 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet got=%b exp=0", bad);
    end
    reset = 1'b1;
    capture(66, 0, 3, -1, '0);
    n_checks++;
    if (cap_bits.size() != 16 || pack_bits() !== 32'h0000_5A60) begin
      n_fail++;
      $display("FAIL midreset_restart got=%h n=%0d exp=5a60", pack_bits(), cap_bits.size());
    end
  endtask

  task automatic test_clkdiv1();
    do_reset();
    do_start(16'hC3A5);
    capture(36, 1, 1, -1, '0);
    n_checks++;
    if (cap_bits.size() != 16 || pack_bits() !== 32'h0000_C3A5) begin
      n_fail++;
      $display("FAIL div1_bits got=%h n=%0d exp=c3a5", pack_bits(), cap_bits.size());
    end
    n_checks++;
    if (cap_done.size() != 1 || cap_done[0] != 31 || act_cnt != 32) begin
      n_fail++;
      $display("FAIL div1_word done_n=%0d act_cnt=%0d exp done at 31 act=32",
               cap_done.size(), act_cnt);
    end
    n_checks++;
    if (cap_rise.size() < 2 || cap_rise[0] != 1 || cap_rise[1] - cap_rise[0] != 2) begin
      n_fail++;
      $display("FAIL div1_bclk_period first_rise=%0d exp first=1 period=2",
               cap_rise.size() > 0 ? cap_rise[0] : -1);
    end
  endtask

`ifdef AUDIO_LRCLK_EN
  task automatic test_lrclk();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (lr0 !== 1'b0) begin
      n_fail++;
      $display("FAIL lrclk_reset got=%b exp=0", lr0);
    end
    do_start(16'h1234);
    capture(195, 0, 140, -1, '0);
    n_checks++;
    if (cap_lr[10] !== 1'b0 || cap_lr[74] !== 1'b1 || cap_lr[138] !== 1'b0) begin
      n_fail++;
      $display("FAIL lrclk_words got=%b%b%b exp=010", cap_lr[10], cap_lr[74], cap_lr[138]);
    end
    n_checks++;
    if (cap_done.size() != 3 || pack_bits() !== 32'h1234_1234) begin
      n_fail++;
      $display("FAIL lrclk_stream done_n=%0d bits=%h exp 3 words", cap_done.size(), pack_bits());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_mid_word_changes();
    test_reset_mid_word();
    test_clkdiv1();
`ifdef AUDIO_LRCLK_EN
    test_lrclk();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
